voter_if_unit: RTL and testbench

- Registered 4-voter tally block: samples a 4-bit ballot vector `I`, one bit per voter (1 = yes).
- Outputs the number of yes votes on `O`, plus majority and tie flags.
- Sits between a voter-input capture stage and downstream decision/display logic; result appears one clock after a valid ballot.

---
 rtl/voter_if_unit.sv | 52 +++++
 tb/tb_voter_if_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/voter_if_unit.sv
// voter_if_unit: registered ballot tally. Counts the yes votes in I and
// registers the count together with majority/tie flags one clock after a
// valid ballot. Results hold while idle; only out_valid drops.
module voter_if_unit #(
    parameter int unsigned N_VOTERS = 4,
    parameter int unsigned CNT_W    = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [N_VOTERS-1:0] I,
    output logic                out_valid,
    output logic [CNT_W-1:0]    O,
    output logic                majority,
    output logic                tie
);

    localparam logic [CNT_W-1:0] HALF    = CNT_W'(N_VOTERS / 2);
    localparam bit               IS_EVEN = (N_VOTERS % 2) == 0;

    logic [CNT_W-1:0] count;
    logic             maj_next;
    logic             tie_next;

    // Popcount of the presented ballot and flag decode from that count
    always_comb begin
        count = '0;
        for (int unsigned k = 0; k < N_VOTERS; k++) begin
            count = count + CNT_W'(I[k]);
        end
        maj_next = (count > HALF);
        tie_next = IS_EVEN && (count == HALF);
    end

    // Result registers: load on a valid ballot, hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            O         <= '0;
            majority  <= 1'b0;
            tie       <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                O        <= count;
                majority <= maj_next;
                tie      <= tie_next;
            end
        end
    end

endmodule

// File: tb/tb_voter_if_unit.sv
// Directed bench for voter_if_unit: default 4-voter instance plus a
// 5-voter variant sharing clock and reset.
module tb_voter_if_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] I;
    logic       out_valid;
    logic [2:0] O;
    logic       majority;
    logic       tie;

    logic       in_valid5;
    logic [4:0] I5;
    logic       out_valid5;
    logic [2:0] O5;
    logic       majority5;
    logic       tie5;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    voter_if_unit #(.N_VOTERS(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .I(I),
        .out_valid(out_valid), .O(O), .majority(majority), .tie(tie)
    );

    voter_if_unit #(.N_VOTERS(5), .CNT_W(3)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid5), .I(I5),
        .out_valid(out_valid5), .O(O5), .majority(majority5), .tie(tie5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [2:0] e_o, input logic e_maj,
                        input logic e_tie, input logic e_ov);
        chk({tag, ".O"},         {29'd0, O},         {29'd0, e_o});
        chk({tag, ".majority"},  {31'd0, majority},  {31'd0, e_maj});
        chk({tag, ".tie"},       {31'd0, tie},       {31'd0, e_tie});
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, e_ov});
    endtask

    task automatic chk5(input string tag, input logic [2:0] e_o, input logic e_maj,
                        input logic e_tie, input logic e_ov);
        chk({tag, ".O5"},         {29'd0, O5},         {29'd0, e_o});
        chk({tag, ".majority5"},  {31'd0, majority5},  {31'd0, e_maj});
        chk({tag, ".tie5"},       {31'd0, tie5},       {31'd0, e_tie});
        chk({tag, ".out_valid5"}, {31'd0, out_valid5}, {31'd0, e_ov});
    endtask

    // Hand-written popcount table for I = 0..15
    int unsigned exp_cnt [16] = '{0, 1, 1, 2, 1, 2, 2, 3, 1, 2, 2, 3, 2, 3, 3, 4};

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        I         = 'x;
        in_valid5 = 1'b0;
        I5        = 'x;

        // Reset state
        #3;
        chk4("reset0", 3'd0, 1'b0, 1'b0, 1'b0);
        chk5("reset0", 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Test 1: get O=3, then async reset mid-cycle
        in_valid = 1'b1;
        I        = 4'b0111;
        @(negedge clk);
        chk4("pre_reset", 3'd3, 1'b1, 1'b0, 1'b1);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk4("async_reset", 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Test 2: exhaustive sweep, one ballot per cycle
        for (int v = 0; v < 16; v++) begin
            in_valid = 1'b1;
            I        = 4'(v);
            @(negedge clk);
            chk4($sformatf("sweep%0d", v), 3'(exp_cnt[v]),
                 exp_cnt[v] >= 3, exp_cnt[v] == 2, 1'b1);
        end

        // Test 3: hold on idle, including X on I
        I = 4'b1011;
        @(negedge clk);
        chk4("hold_load", 3'd3, 1'b1, 1'b0, 1'b1);
        in_valid = 1'b0;
        I        = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk4($sformatf("hold%0d", c), 3'd3, 1'b1, 1'b0, 1'b0);
        end
        I = 'x;
        @(negedge clk);
        chk4("hold_x", 3'd3, 1'b1, 1'b0, 1'b0);

        // Test 4: back-to-back ballots
        in_valid = 1'b1;
        I        = 4'b1111;
        @(negedge clk);
        chk4("b2b0", 3'd4, 1'b1, 1'b0, 1'b1);
        I = 4'b0000;
        @(negedge clk);
        chk4("b2b1", 3'd0, 1'b0, 1'b0, 1'b1);
        I = 4'b1010;
        @(negedge clk);
        chk4("b2b2", 3'd2, 1'b0, 1'b1, 1'b1);

        // Test 5: reset mid-stream discards the pending 1110 ballot
        I = 4'b1110;
        #2;
        rst_n = 1'b0;
        #1;
        chk4("mid_reset", 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk4("mid_reset_hold0", 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk4("mid_reset_hold1", 3'd0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        chk4("post_release", 3'd0, 1'b0, 1'b0, 1'b0);

        // Test 6: 5-voter variant, tie is always 0
        in_valid5 = 1'b1;
        I5        = 5'b11100;
        @(negedge clk);
        chk5("v5_a", 3'd3, 1'b1, 1'b0, 1'b1);
        I5 = 5'b11000;
        @(negedge clk);
        chk5("v5_b", 3'd2, 1'b0, 1'b0, 1'b1);
        I5 = 5'b11111;
        @(negedge clk);
        chk5("v5_c", 3'd5, 1'b1, 1'b0, 1'b1);
        in_valid5 = 1'b0;
        I5        = 5'b00000;
        @(negedge clk);
        chk5("v5_idle", 3'd5, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
